// File: rtl/ct_ciu_regs_arb.sv
// Round-robin arbiter/sequencer sharing the CIU cluster register bank between core CSR ports.
// Optional write-protection check enabled by CIU_REGS_ARB_RO_CHK_EN.
module ct_ciu_regs_arb #(
   parameter int unsigned CORE_NUM = 4,
   parameter int unsigned IDX_W    = 4,
   parameter int unsigned DATA_W   = 64
) (
   input  logic                         smpr_clk,
   input  logic                         x_fifo_rst_b,
   input  logic [CORE_NUM-1:0]          core_regs_req,
   input  logic [CORE_NUM-1:0]          core_regs_wen,
   input  logic [CORE_NUM*IDX_W-1:0]    core_regs_idx,
   input  logic [CORE_NUM*DATA_W-1:0]   core_regs_wdata,
   input  logic [CORE_NUM*4-1:0]        core_regs_l2of_wen,
   input  logic [DATA_W-1:0]            x_csr_value,
   output logic                         regs_sel_final_x,
   output logic                         regs_wen,
   output logic [IDX_W-1:0]             regs_idx,
   output logic [DATA_W-1:0]            regs_wdata_final,
   output logic [3:0]                   regs_l2of_wen,
   output logic [CORE_NUM-1:0]          regs_ack,
   output logic [DATA_W-1:0]            regs_rdata,
   output logic                         regs_err
);

   localparam int unsigned PTR_W = (CORE_NUM > 1) ? $clog2(CORE_NUM) : 1;

   typedef enum logic [1:0] {IDLE, SEL, RESP} state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [PTR_W-1:0]     grant_q, grant_d;
   logic                 sel_q, sel_d;
   logic                 wen_q, wen_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0]    wdata_q, wdata_d;
   logic [3:0]           l2of_q, l2of_d;
   logic [CORE_NUM-1:0]  ack_q, ack_d;
   logic [DATA_W-1:0]    rdata_q, rdata_d;
   logic                 pick_wen;
   logic [IDX_W-1:0]     pick_idx;

   logic [PTR_W-1:0]     pick_c;
   logic                 found_c;
   logic [PTR_W:0]       cand_c;

   // first requesting core at or after the pointer, modulo CORE_NUM
   always_comb begin
      pick_c  = '0;
      found_c = 1'b0;
      cand_c  = '0;
      for (int i = 0; i < int'(CORE_NUM); i++) begin
         cand_c = {1'b0, ptr_q} + (PTR_W+1)'(i);
         if (cand_c >= (PTR_W+1)'(CORE_NUM))
            cand_c = cand_c - (PTR_W+1)'(CORE_NUM);
         if (!found_c && core_regs_req[cand_c[PTR_W-1:0]]) begin
            found_c = 1'b1;
            pick_c  = cand_c[PTR_W-1:0];
         end
      end
   end

   assign pick_wen = core_regs_wen[pick_c];
   assign pick_idx = core_regs_idx[int'(pick_c)*IDX_W +: IDX_W];

`ifdef CIU_REGS_ARB_RO_CHK_EN
   logic blk_q, blk_d;
   logic err_q, err_d;
   logic pick_blk;

   // only the writable cluster registers accept writes
   assign pick_blk = pick_wen && !(pick_idx inside {IDX_W'(4), IDX_W'(8), IDX_W'(9),
                                                    IDX_W'(10), IDX_W'(11), IDX_W'(12)});
`endif

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      sel_d   = 1'b0;
      wen_d   = 1'b0;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      l2of_d  = l2of_q;
      ack_d   = '0;
      rdata_d = '0;
`ifdef CIU_REGS_ARB_RO_CHK_EN
      blk_d   = blk_q;
      err_d   = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            if (found_c) begin
               grant_d = pick_c;
               sel_d   = 1'b1;
`ifdef CIU_REGS_ARB_RO_CHK_EN
               blk_d   = pick_blk;
               wen_d   = pick_wen && !pick_blk;
`else
               wen_d   = pick_wen;
`endif
               idx_d   = pick_idx;
               wdata_d = core_regs_wdata[int'(pick_c)*DATA_W +: DATA_W];
               l2of_d  = core_regs_l2of_wen[int'(pick_c)*4 +: 4];
               state_d = SEL;
            end
         end
         SEL: begin
            // bank value sampled here; for writes it is the pre-write value
            ack_d[grant_q] = 1'b1;
            rdata_d        = x_csr_value;
`ifdef CIU_REGS_ARB_RO_CHK_EN
            err_d          = blk_q;
`endif
            state_d        = RESP;
         end
         RESP: begin
            ptr_d   = (grant_q == PTR_W'(CORE_NUM-1)) ? '0 : grant_q + PTR_W'(1);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge smpr_clk or negedge x_fifo_rst_b) begin
      if (!x_fifo_rst_b) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         sel_q   <= 1'b0;
         wen_q   <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         l2of_q  <= '0;
         ack_q   <= '0;
         rdata_q <= '0;
`ifdef CIU_REGS_ARB_RO_CHK_EN
         blk_q   <= 1'b0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         sel_q   <= sel_d;
         wen_q   <= wen_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         l2of_q  <= l2of_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
`ifdef CIU_REGS_ARB_RO_CHK_EN
         blk_q   <= blk_d;
         err_q   <= err_d;
`endif
      end
   end

   assign regs_sel_final_x = sel_q;
   assign regs_wen         = wen_q;
   assign regs_idx         = idx_q;
   assign regs_wdata_final = wdata_q;
   assign regs_l2of_wen    = l2of_q;
   assign regs_ack         = ack_q;
   assign regs_rdata       = rdata_q;
`ifdef CIU_REGS_ARB_RO_CHK_EN
   assign regs_err         = err_q;
`else
   assign regs_err         = 1'b0;
`endif

endmodule

// File: tb/tb_ct_ciu_regs_arb.sv
// Directed plus randomized bench for ct_ciu_regs_arb against a per-transaction reference model.
module tb_ct_ciu_regs_arb;

   logic          smpr_clk;
   logic          x_fifo_rst_b;
   logic [3:0]    req_v;
   logic [3:0]    wen_v;
   logic [15:0]   idx_bus;
   logic [255:0]  wd_bus;
   logic [15:0]   l2_bus;
   logic [63:0]   x_csr_value;
   logic          regs_sel_final_x;
   logic          regs_wen;
   logic [3:0]    regs_idx;
   logic [63:0]   regs_wdata_final;
   logic [3:0]    regs_l2of_wen;
   logic [3:0]    regs_ack;
   logic [63:0]   regs_rdata;
   logic          regs_err;

   logic          wen_a [4];
   logic [3:0]    idx_a [4];
   logic [63:0]   wd_a  [4];
   logic [3:0]    l2_a  [4];

   int n_tests = 0;
   int n_fail  = 0;
   int ptr_m   = 0;

   ct_ciu_regs_arb #(.CORE_NUM(4), .IDX_W(4), .DATA_W(64)) dut (
      .smpr_clk           (smpr_clk),
      .x_fifo_rst_b       (x_fifo_rst_b),
      .core_regs_req      (req_v),
      .core_regs_wen      (wen_v),
      .core_regs_idx      (idx_bus),
      .core_regs_wdata    (wd_bus),
      .core_regs_l2of_wen (l2_bus),
      .x_csr_value        (x_csr_value),
      .regs_sel_final_x   (regs_sel_final_x),
      .regs_wen           (regs_wen),
      .regs_idx           (regs_idx),
      .regs_wdata_final   (regs_wdata_final),
      .regs_l2of_wen      (regs_l2of_wen),
      .regs_ack           (regs_ack),
      .regs_rdata         (regs_rdata),
      .regs_err           (regs_err)
   );

   initial smpr_clk = 1'b0;
   always #5 smpr_clk = ~smpr_clk;

   always_comb begin
      for (int c = 0; c < 4; c++) begin
         wen_v[c]               = wen_a[c];
         idx_bus[c*4 +: 4]      = idx_a[c];
         wd_bus[c*64 +: 64]     = wd_a[c];
         l2_bus[c*4 +: 4]       = l2_a[c];
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic logic idx_writable(input logic [3:0] i);
      return (i == 4'h4) || (i == 4'h8) || (i == 4'h9) ||
             (i == 4'ha) || (i == 4'hb) || (i == 4'hc);
   endfunction

   task automatic set_req(input int c, input logic w, input logic [3:0] i,
                          input logic [63:0] d, input logic [3:0] m);
      wen_a[c] = w;
      idx_a[c] = i;
      wd_a[c]  = d;
      l2_a[c]  = m;
      req_v[c] = 1'b1;
   endtask

   // Called #1 into an IDLE cycle with requests applied; returns #1 into the next IDLE cycle.
   task automatic step_txn(input int forced, input logic [63:0] bank);
      int          w;
      logic        ew, ee;
      logic [3:0]  exp_ack;
      w = (forced >= 0) ? forced : model_pick(req_v, ptr_m);
`ifdef CIU_REGS_ARB_RO_CHK_EN
      ew = wen_a[w] && idx_writable(idx_a[w]);
      ee = wen_a[w] && !idx_writable(idx_a[w]);
`else
      ew = wen_a[w];
      ee = 1'b0;
`endif
      @(posedge smpr_clk); #1;
      check("sel_t1",   64'(regs_sel_final_x), 64'(1'b1));
      check("wen_t1",   64'(regs_wen), 64'(ew));
      check("idx_t1",   64'(regs_idx), 64'(idx_a[w]));
      check("wdata_t1", regs_wdata_final, wd_a[w]);
      check("l2of_t1",  64'(regs_l2of_wen), 64'(l2_a[w]));
      check("ack_t1",   64'(regs_ack), 64'(0));
      x_csr_value = bank;
      @(posedge smpr_clk); #1;
      exp_ack = 4'b0001 << w;
      check("ack_t2",   64'(regs_ack), 64'(exp_ack));
      check("rdata_t2", regs_rdata, bank);
      check("err_t2",   64'(regs_err), 64'(ee));
      check("sel_t2",   64'(regs_sel_final_x), 64'(0));
      check("wen_t2",   64'(regs_wen), 64'(0));
      req_v[w] = 1'b0;
      ptr_m    = (w + 1) % 4;
      @(posedge smpr_clk); #1;
      check("ack_t3",   64'(regs_ack), 64'(0));
      check("rdata_t3", regs_rdata, 64'(0));
      check("err_t3",   64'(regs_err), 64'(0));
      check("idx_hold", 64'(regs_idx), 64'(idx_a[w]));
   endtask

   initial begin
      x_fifo_rst_b = 1'b0;
      req_v        = '0;
      x_csr_value  = '0;
      for (int c = 0; c < 4; c++) begin
         wen_a[c] = 1'b0; idx_a[c] = '0; wd_a[c] = '0; l2_a[c] = '0;
      end
      repeat (3) @(posedge smpr_clk);
      #1;
      check("rst_sel",   64'(regs_sel_final_x), 64'(0));
      check("rst_ack",   64'(regs_ack), 64'(0));
      check("rst_wdata", regs_wdata_final, 64'(0));
      check("rst_rdata", regs_rdata, 64'(0));
      x_fifo_rst_b = 1'b1;
      @(posedge smpr_clk); #1;
      check("idle_sel", 64'(regs_sel_final_x), 64'(0));

      // core0 read of idx 4
      set_req(0, 1'b0, 4'h4, 64'h0, 4'h0);
      step_txn(0, 64'h1);
      // core2 write of idx 8
      set_req(2, 1'b1, 4'h8, 64'hDEAD_BEEF, 4'h3);
      step_txn(2, 64'h5);
      // core3 alone, moves pointer to 0
      set_req(3, 1'b0, 4'h9, 64'h0, 4'h0);
      step_txn(3, 64'h33);

      // all four continuously: 0,1,2,3,0
      for (int c = 0; c < 4; c++) set_req(c, 1'b0, 4'(c + 4), 64'(c), 4'(c));
      step_txn(0, 64'h100);
      set_req(0, 1'b1, 4'ha, 64'hA0A0, 4'h5);
      step_txn(1, 64'h101);
      step_txn(2, 64'h102);
      step_txn(3, 64'h103);
      step_txn(0, 64'h104);

      // core1 grant leaves pointer at 2; then cores 0 and 3 together
      set_req(1, 1'b0, 4'hb, 64'h0, 4'h0);
      step_txn(1, 64'h11);
      set_req(0, 1'b0, 4'hc, 64'h0, 4'h0);
      set_req(3, 1'b1, 4'h4, 64'h1234, 4'hf);
      step_txn(3, 64'h22);
      step_txn(0, 64'h23);

      // write to non-writable index 5
      set_req(0, 1'b1, 4'h5, 64'hFFFF, 4'h1);
      step_txn(0, 64'h55);

      // reset pulsed during SEL, pointer currently 1
      set_req(2, 1'b1, 4'h8, 64'hCAFE, 4'h2);
      @(posedge smpr_clk); #1;
      check("pre_rst_sel", 64'(regs_sel_final_x), 64'(1));
      x_fifo_rst_b = 1'b0;
      req_v        = '0;
      #1;
      check("async_sel",   64'(regs_sel_final_x), 64'(0));
      check("async_wen",   64'(regs_wen), 64'(0));
      check("async_idx",   64'(regs_idx), 64'(0));
      check("async_wdata", regs_wdata_final, 64'(0));
      @(posedge smpr_clk); #1;
      x_fifo_rst_b = 1'b1;
      ptr_m        = 0;
      @(posedge smpr_clk); #1;
      check("post_rst_ack", 64'(regs_ack), 64'(0));
      set_req(1, 1'b0, 4'h9, 64'h0, 4'h0);
      set_req(3, 1'b0, 4'ha, 64'h0, 4'h0);
      step_txn(1, 64'h77);
      step_txn(3, 64'h78);

      // randomized traffic against the model
      for (int it = 0; it < 200; it++) begin
         for (int c = 0; c < 4; c++)
            if (!req_v[c] && $urandom_range(0, 2) == 0)
               set_req(c, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       {$urandom, $urandom}, 4'($urandom));
         if (|req_v) begin
            step_txn(-1, {$urandom, $urandom});
         end else begin
            @(posedge smpr_clk); #1;
            check("rand_idle_sel", 64'(regs_sel_final_x), 64'(0));
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ct_ciu_regs_arb.md
Name: ct_ciu_regs_arb

Overview:
- Arbiter and sequencer that shares the CIU cluster register bank (SMPR/TEEM/L2RA/L2RM/L2WA/L2WM/L2OF) between CORE_NUM core CSR access ports.
- Picks one core per transaction using round-robin and drives the bank's select, write-enable, index, write-data and L2OF bit-mask inputs for exactly one cycle.
- Captures the bank's read value and returns it with a one-cycle ack to the granted core.

Parameters:
- CORE_NUM, 4, number of requesting core ports (2..8).
- IDX_W, 4, register index width.
- DATA_W, 64, register data width.

Ports:
- smpr_clk  in  1  clock.
- x_fifo_rst_b  in  1  reset; asynchronous, active-low.
- core_regs_req  in  CORE_NUM  per-core access request; held until ack.
- core_regs_wen  in  CORE_NUM  per-core access type; 1 = write, 0 = read.
- core_regs_idx  in  CORE_NUM*IDX_W  per-core register index; core i occupies [i*IDX_W +: IDX_W].
- core_regs_wdata  in  CORE_NUM*DATA_W  per-core write data.
- core_regs_l2of_wen  in  CORE_NUM*4  per-core L2OF bit write mask.
- x_csr_value  in  DATA_W  read mux output of the register bank.
- regs_sel_final_x  out  1  bank select strobe.
- regs_wen  out  1  bank write enable.
- regs_idx  out  IDX_W  bank index.
- regs_wdata_final  out  DATA_W  bank write data.
- regs_l2of_wen  out  4  bank L2OF bit mask.
- regs_ack  out  CORE_NUM  one-hot completion pulse.
- regs_rdata  out  DATA_W  read data, valid while ack is high.
- regs_err  out  1  access error, valid while ack is high.

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- Reset also clears: FSM = IDLE, round-robin pointer = 0, grant = 0.
- FSM states: IDLE, SEL, RESP.
- IDLE:
  - If any req is high, grant the first requesting core at or after the pointer (modulo CORE_NUM).
  - Latch that core's wen, idx, wdata and l2of_wen into regs_wen (qualified), regs_idx, regs_wdata_final and regs_l2of_wen.
  - Set regs_sel_final_x = 1 and go to SEL.
  - Otherwise stay in IDLE.
- SEL (exactly 1 cycle):
  - regs_sel_final_x = 1 and regs_wen = latched wen.
  - x_csr_value is captured into regs_rdata at the end of the cycle. For a write this is the pre-write value.
  - Deassert sel and wen, then go to RESP.
- RESP (1 cycle):
  - regs_ack[grant] = 1 and regs_rdata/regs_err are valid.
  - Pointer = grant + 1, wrapping CORE_NUM-1 to 0. Go to IDLE.
  - regs_ack, regs_err and regs_rdata return to 0 on the next cycle.
- regs_idx, regs_wdata_final and regs_l2of_wen hold their last value outside SEL, so the read mux stays stable.
- Latency: req high in an IDLE cycle (T0) gives sel in T1 and ack in T2. Maximum throughput is one access per 3 cycles.
- Requester protocol:
  - req and its payload must stay stable from assertion until ack.
  - req must be low in the cycle after ack unless a new access is intended.
  - A req that drops before ack does not abort the transaction: the access and the ack still occur.
- Arbitration is evaluated only in IDLE. Requests arriving during SEL/RESP wait.
- Simultaneous requests: the winner is the lowest core index at or after the pointer. No core waits more than CORE_NUM-1 transactions.
- The L2OF mask passes through unmodified; bit merging is done by the bank.
- Reset asserted mid-transaction aborts immediately: no ack is issued, and sel/wen drop asynchronously.

Optional Feature:
- Macro: CIU_REGS_ARB_RO_CHK_EN.
- Defined:
  - A write to an index outside {4,8,9,a,b,c} is blocked: regs_wen is forced 0 in SEL (sel still asserted).
  - regs_err = 1 with the ack; regs_rdata still returns x_csr_value.
  - Reads never error.
- Undefined: regs_wen passes through unconditionally, regs_err is tied 0, and no index decode logic is present.

Test Plan:
- Core0 reads idx 4 while the bank returns 64'h1. Required: sel at T1 with wen 0, regs_ack = 4'b0001 at T2, regs_rdata = 64'h1, err 0.
- Core2 writes idx 8 with wdata 64'hDEAD_BEEF while the bank returns 64'h5. Required: in T1, sel = 1, wen = 1, idx = 8, wdata = 64'hDEAD_BEEF; ack = 4'b0100 at T2; rdata = 64'h5.
- All four cores request continuously. Required: grants in order 0,1,2,3,0, one ack every 3 cycles, pointer wraps 3 to 0.
- Pointer at 2 after a core1 grant, then cores 0 and 3 request together. Required: core3 is granted first, then core0.
- Reset pulsed during SEL. Required: all outputs 0 immediately, no ack; the next request from core1 is granted after core0 is checked first (pointer = 0).
- With CIU_REGS_ARB_RO_CHK_EN defined, core0 writes idx 5. Required: sel = 1, wen = 0, ack with regs_err = 1. With the macro undefined: wen = 1, err = 0.
